lut_arbiter: RTL and testbench
==============================

// Module: lut_arbiter
// PURPOSE
// Round-robin arbiter that shares one read port of the LSE correction LUT among NUM_REQ LSE adder lanes.
// Each cycle it grants at most one lane and captures that lane's LUT entry in a per-lane response register.
// The response register holds until the lane accepts it.
// Sits between the lut module (o_values bus) and the LSE-PE adders; models a single-ported CLUT.
// PARAMETERS
// NUM_REQ      4                  number of requesting lanes (>=2)
// ENTRIES      16                 LUT depth; must match lut.ENTRIES
// ENTRY_WIDTH  10                 signed LUT entry width; must match lut.ENTRY_WIDTH
// IDX_WIDTH    $clog2(ENTRIES)    lookup index width
// PORTS
// i_clk        in   1                        clock, all state on rising edge
// i_rst        in   1                        reset, asynchronous, active-high
// i_lut_values in   ENTRIES x ENTRY_WIDTH    signed LUT contents (from lut.o_values)
// i_req_valid  in   NUM_REQ                  lane i requests a lookup
// i_req_idx    in   NUM_REQ x IDX_WIDTH      lane i lookup index; stable while valid and not ready
// o_req_ready  out  NUM_REQ                  one-hot grant; request i consumed when valid&ready
// o_rsp_valid  out  NUM_REQ                  response register i holds data
// o_rsp_data   out  NUM_REQ x ENTRY_WIDTH    signed LUT value for lane i
// i_rsp_ready  in   NUM_REQ                  lane i accepts its response
// o_busy       out  1                        any o_rsp_valid set or any request pending
// BEHAVIOUR
// Reset (async assert, sync release):
//   o_rsp_valid=0, o_rsp_data=0, rr_ptr=NUM_REQ-1 (lane 0 has top priority after reset).
//   o_req_ready is combinational and therefore 0 while in reset.
// Eligibility: elig[i] = i_req_valid[i] & (~o_rsp_valid[i] | i_rsp_ready[i]).
//   A full response slot blocks its lane unless the slot drains in the same cycle.
// Arbitration: combinational search starting at lane (rr_ptr+1) mod NUM_REQ with wrap-around.
//   The first eligible lane is granted: o_req_ready = one-hot of that lane, else all zero.
//   o_req_ready may depend on i_req_valid; requesters must not gate valid on ready.
// Pointer: on any grant, rr_ptr <= granted lane; with no grant, rr_ptr holds.
//   Fairness bound: a continuously eligible lane is granted within NUM_REQ cycles.
// Latency: one cycle. Grant at edge N sets o_rsp_valid[g]=1 and o_rsp_data[g]=i_lut_values[idx] after edge N.
// Drain: o_rsp_valid[i] & i_rsp_ready[i] with no grant to i -> clear o_rsp_valid[i]; o_rsp_data[i] holds its value.
// Simultaneous drain + grant on same lane: the new data overwrites; valid stays 1 (back-to-back, 1 result/cycle).
// Hold: o_rsp_valid[i] & ~i_rsp_ready[i] -> data and valid frozen, no new grant to lane i.
// Width: i_lut_values is passed through sign-intact, with no arithmetic.
//   An index >= ENTRIES (only possible for non-power-of-2 ENTRIES) returns 0.
// No grant in a cycle: all response registers are unchanged apart from drains.
// Reset mid-operation: all pending responses are discarded (valid->0) immediately on i_rst assert.
//   Requesters must re-issue their requests.
// o_busy = |i_req_valid | |o_rsp_valid (combinational).
// TESTING
// 1 Reset: assert i_rst mid-stream with rsp_valid=4'b1011.
//   -> o_rsp_valid=0 and o_rsp_data=0 asynchronously.
//   -> After release, lane 0 wins when all four request.
// 2 Single lane: lane2 valid with idx=8, rsp_ready=1, default lut.
//   -> ready[2]=1 in the same cycle.
//   -> Next cycle rsp_valid[2]=1 and rsp_data[2]=82.
// 3 Round-robin: all 4 lanes valid continuously, rsp_ready=4'hF.
//   -> Grant order is 0,1,2,3,0,1.
//   -> Each lane gets exactly one grant per 4 cycles.
// 4 Backpressure: lane1 gets idx=4 (data 67) with rsp_ready[1]=0, then requests again with idx=0.
//   -> No grant to lane 1 while blocked; data stays 67.
//   -> Raise rsp_ready[1]: grant occurs in that cycle and data becomes 3 the next cycle, with no valid gap.
// 5 Negative/extreme values: load i_lut_values[15]=10'sh200 (-512), lane3 idx=15.
//   -> rsp_data[3]=10'sh200 (-512), bit-exact.
// 6 Random: randomized valid/idx/rsp_ready over 10k cycles, checked against a scoreboard.
//   -> Zero lost or duplicated responses.
//   -> o_req_ready always one-hot or zero.
//   -> Fairness bound holds.

Source files
------------

// File: rtl/lut_arbiter.sv
// Round-robin arbiter sharing one LSE correction LUT read port
// among NUM_REQ lanes, with a per-lane registered response slot.
`timescale 1ns/1ps
module lut_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ENTRIES     = 16,
  parameter int ENTRY_WIDTH = 10,
  parameter int IDX_WIDTH   = $clog2(ENTRIES)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [ENTRIES-1:0][ENTRY_WIDTH-1:0]  i_lut_values,
  input  logic [NUM_REQ-1:0]                   i_req_valid,
  input  logic [NUM_REQ-1:0][IDX_WIDTH-1:0]    i_req_idx,
  output logic [NUM_REQ-1:0]                   o_req_ready,
  output logic [NUM_REQ-1:0]                   o_rsp_valid,
  output logic [NUM_REQ-1:0][ENTRY_WIDTH-1:0]  o_rsp_data,
  input  logic [NUM_REQ-1:0]                   i_rsp_ready,
  output logic                                 o_busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]          rr_ptr;
  logic [NUM_REQ-1:0]     elig;
  logic [NUM_REQ-1:0]     grant;
  logic [PW-1:0]          gsel;
  logic                   found;
  logic [IDX_WIDTH-1:0]   sel_idx;
  logic [ENTRY_WIDTH-1:0] sel_val;

  // a full slot only blocks its lane if it is not draining now
  assign elig = i_req_valid & (~o_rsp_valid | i_rsp_ready);

  always_comb begin
    int l;
    grant = '0;
    gsel  = '0;
    found = 1'b0;
    l     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      l = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && !i_rst && elig[l]) begin
        found    = 1'b1;
        grant[l] = 1'b1;
        gsel     = PW'(l);
      end
    end
  end

  assign sel_idx = i_req_idx[gsel];

  if ((1 << IDX_WIDTH) > ENTRIES) begin : g_clip
    assign sel_val = (int'(sel_idx) < ENTRIES)
                   ? i_lut_values[sel_idx] : '0;
  end else begin : g_full
    assign sel_val = i_lut_values[sel_idx];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr      <= PW'(NUM_REQ - 1);
      o_rsp_valid <= '0;
      o_rsp_data  <= '0;
    end else begin
      if (found) rr_ptr <= gsel;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          o_rsp_valid[i] <= 1'b1;
          o_rsp_data[i]  <= sel_val;
        end else if (i_rsp_ready[i]) begin
          o_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign o_req_ready = grant;
  assign o_busy      = (|i_req_valid) | (|o_rsp_valid);

endmodule

// File: tb/tb_lut_arbiter.sv
// Directed and randomized bench for lut_arbiter with
// hand-computed expectations and a small response scoreboard.
`timescale 1ns/1ps
module tb_lut_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0][9:0]  lut;
  logic [3:0]        req_valid;
  logic [3:0][3:0]   req_idx;
  logic [3:0]        req_ready;
  logic [3:0]        rsp_valid;
  logic [3:0][9:0]   rsp_data;
  logic [3:0]        rsp_ready;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lut_arbiter #(
    .NUM_REQ(4), .ENTRIES(16), .ENTRY_WIDTH(10), .IDX_WIDTH(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_lut_values(lut),
    .i_req_valid(req_valid),
    .i_req_idx(req_idx),
    .o_req_ready(req_ready),
    .o_rsp_valid(rsp_valid),
    .o_rsp_data(rsp_data),
    .i_rsp_ready(rsp_ready),
    .o_busy(busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    req_valid = '0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step;
  endtask

  task automatic load_lut;
    lut[0]  = 10'd3;     lut[1]  = 10'd10;
    lut[2]  = 10'd25;    lut[3]  = 10'd41;
    lut[4]  = 10'd67;    lut[5]  = -10'sd7;
    lut[6]  = 10'd100;   lut[7]  = -10'sd200;
    lut[8]  = 10'd82;    lut[9]  = 10'd511;
    lut[10] = -10'sd1;   lut[11] = 10'd0;
    lut[12] = 10'd12;    lut[13] = -10'sd100;
    lut[14] = 10'd255;   lut[15] = -10'sd300;
  endtask

  task automatic test_reset;
    logic [3:0][9:0] exp_d;
    rst = 1'b1;
    req_valid = 4'hF;
    req_idx = '0;
    rsp_ready = 4'h0;
    #2;
    checks++;
    if (rsp_valid !== 4'h0 || rsp_data !== '0)
      $display("FAIL rst_init got %h/%h want 0/0",
               rsp_valid, rsp_data);
    checks++;
    if (req_ready !== 4'h0)
      $display("FAIL rst_ready got %b want 0000", req_ready);
    checks++;
    if (busy !== 1'b1)
      $display("FAIL rst_busy got %b want 1", busy);
    errors += (rsp_valid !== 4'h0 || rsp_data !== '0) ? 1 : 0;
    errors += (req_ready !== 4'h0) ? 1 : 0;
    errors += (busy !== 1'b1) ? 1 : 0;
    req_valid = '0;
    #1;
    rst = 1'b0;
    step;
    req_valid = 4'b1011;
    req_idx[0] = 4'd0;
    req_idx[1] = 4'd1;
    req_idx[3] = 4'd3;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_g0 got %b want 0001", req_ready);
    end
    step;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rst_g1 got %b want 0010", req_ready);
    end
    step;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL rst_g3 got %b want 1000", req_ready);
    end
    step;
    exp_d = '0;
    exp_d[0] = 10'd3;
    exp_d[1] = 10'd10;
    exp_d[3] = 10'd41;
    checks++;
    if (rsp_valid !== 4'b1011 || rsp_data !== exp_d) begin
      errors++;
      $display("FAIL rst_fill got %b/%h want 1011/%h",
               rsp_valid, rsp_data, exp_d);
    end
    req_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 4'h0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL rst_async got %b/%h want 0/0",
               rsp_valid, rsp_data);
    end
    rst = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_prio got %b want 0001", req_ready);
    end
    req_valid = '0;
    step;
  endtask

  task automatic test_single;
    rsp_ready = 4'hF;
    req_valid = 4'b0100;
    req_idx[2] = 4'd8;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_rdy got %b want 0100", req_ready);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy got %b want 1", busy);
    end
    step;
    req_valid = '0;
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_data[2] !== 10'd82) begin
      errors++;
      $display("FAIL single_rsp got %b/%0d want 0100/82",
               rsp_valid, rsp_data[2]);
    end
    step;
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_drain got %b/%b want 0000/0",
               rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0][9:0] vals;
    logic [3:0] want;
    int cnt[4];
    vals[0] = 10'd10;
    vals[1] = 10'd25;
    vals[2] = 10'd41;
    vals[3] = 10'd67;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    pulse_reset;
    rsp_ready = 4'hF;
    for (int i = 0; i < 4; i++) req_idx[i] = 4'(i + 1);
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      want = 4'b0001 << (k % 4);
      checks++;
      if (req_ready !== want) begin
        errors++;
        $display("FAIL rr_order k=%0d got %b want %b",
                 k, req_ready, want);
      end
      for (int i = 0; i < 4; i++)
        if (req_ready[i]) cnt[i]++;
      step;
      checks++;
      if (rsp_data[k % 4] !== vals[k % 4]) begin
        errors++;
        $display("FAIL rr_data k=%0d got %0d want %0d",
                 k, rsp_data[k % 4], vals[k % 4]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cnt[i] != 2) begin
        errors++;
        $display("FAIL rr_count lane%0d got %0d want 2",
                 i, cnt[i]);
      end
    end
    req_valid = '0;
    step;
  endtask

  task automatic test_backpressure;
    rsp_ready = 4'b1101;
    req_valid = 4'b0010;
    req_idx[1] = 4'd4;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_first got %b want 0010", req_ready);
    end
    step;
    req_idx[1] = 4'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid[1] !== 1'b1 ||
          rsp_data[1] !== 10'd67) begin
        errors++;
        $display("FAIL bp_hold k=%0d got %b/%b/%0d want 0000/1/67",
                 k, req_ready, rsp_valid[1], rsp_data[1]);
      end
      step;
    end
    rsp_ready = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release got %b want 0010", req_ready);
    end
    step;
    req_valid = '0;
    checks++;
    if (rsp_valid[1] !== 1'b1 || rsp_data[1] !== 10'd3) begin
      errors++;
      $display("FAIL bp_b2b got %b/%0d want 1/3",
               rsp_valid[1], rsp_data[1]);
    end
    step;
    checks++;
    if (rsp_valid[1] !== 1'b0 || rsp_data[1] !== 10'd3) begin
      errors++;
      $display("FAIL bp_drain got %b/%0d want 0/3",
               rsp_valid[1], rsp_data[1]);
    end
  endtask

  task automatic test_extreme;
    lut[15] = 10'h200;
    rsp_ready = 4'hF;
    req_idx[3] = 4'd15;
    req_idx[0] = 4'd9;
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL ext_order got %b want 1000", req_ready);
    end
    step;
    req_valid = 4'b0001;
    checks++;
    if (rsp_data[3] !== 10'h200) begin
      errors++;
      $display("FAIL ext_neg got %h want 200", rsp_data[3]);
    end
    step;
    req_valid = '0;
    checks++;
    if (rsp_data[0] !== 10'h1FF || rsp_data[3] !== 10'h200) begin
      errors++;
      $display("FAIL ext_pos got %h/%h want 1ff/200",
               rsp_data[0], rsp_data[3]);
    end
    step;
  endtask

  task automatic test_random;
    logic [3:0]      ev;
    logic [3:0][9:0] ed;
    logic [3:0]      rv;
    logic [3:0][3:0] ri;
    logic [3:0]      g;
    logic [3:0]      el;
    int              wt[4];
    bit              unfair;
    pulse_reset;
    for (int e = 0; e < 16; e++) lut[e] = 10'($urandom);
    ev = '0;
    ed = '0;
    rv = '0;
    ri = '0;
    for (int i = 0; i < 4; i++) wt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int l = 0; l < 4; l++)
        if (!rv[l] && $urandom_range(0, 2) == 0) begin
          rv[l] = 1'b1;
          ri[l] = 4'($urandom);
        end
      req_valid = rv;
      req_idx = ri;
      rsp_ready = 4'($urandom) | 4'($urandom);
      #1;
      g = req_ready;
      el = rv & (~ev | rsp_ready);
      checks++;
      if ((g & (g - 4'd1)) != 4'd0 || (g & ~el) != 4'd0 ||
          (el != 4'd0 && g == 4'd0)) begin
        errors++;
        $display("FAIL rnd_grant cyc=%0d got %b elig %b",
                 cyc, g, el);
      end
      unfair = 1'b0;
      for (int l = 0; l < 4; l++) begin
        if (el[l] && !g[l]) wt[l]++;
        else wt[l] = 0;
        if (wt[l] >= 4) unfair = 1'b1;
      end
      checks++;
      if (unfair) begin
        errors++;
        $display("FAIL rnd_fair cyc=%0d waits %0d %0d %0d %0d want <4",
                 cyc, wt[0], wt[1], wt[2], wt[3]);
      end
      for (int l = 0; l < 4; l++) begin
        if (g[l]) begin
          ev[l] = 1'b1;
          ed[l] = lut[ri[l]];
          rv[l] = 1'($urandom_range(0, 1));
          ri[l] = 4'($urandom);
        end else if (rsp_ready[l]) begin
          ev[l] = 1'b0;
        end
      end
      step;
      checks++;
      if (rsp_valid !== ev) begin
        errors++;
        $display("FAIL rnd_valid cyc=%0d got %b want %b",
                 cyc, rsp_valid, ev);
      end
      checks++;
      if (rsp_data !== ed) begin
        errors++;
        $display("FAIL rnd_data cyc=%0d got %h want %h",
                 cyc, rsp_data, ed);
      end
    end
    req_valid = '0;
    rsp_ready = 4'hF;
    step;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 4'h0) begin
      errors++;
      $display("FAIL rnd_idle got %b/%b want 0/0",
               busy, rsp_valid);
    end
  endtask

  initial begin
    load_lut;
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_extreme;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
